// File: rtl/fifo_rd_unpacker.sv
// Reads wide words from a FIFO (first-word-fall-through or standard read latency 1)
// and streams them out as narrow beats over a valid/ready interface.
module fifo_rd_unpacker #(
  parameter int    IN_WIDTH  = 128,
  parameter int    OUT_WIDTH = 16,
  parameter string MODE      = "FWFT",
  parameter string DIRECTION = "LSB"
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_valid,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int NB    = 1 << CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);
  localparam bit IS_FWFT = (MODE == "FWFT");
  localparam bit IS_MSB  = (DIRECTION == "MSB");

  logic [IN_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                held_q, held_d;
  logic                pending_q, pending_d;

  logic                xfer;
  logic                load;
  logic [OUT_WIDTH-1:0] beat_mux [NB];

  // Beat slices of the held word; entries beyond RATIO pad the mux to a power of two.
  for (genvar k = 0; k < NB; k++) begin : g_beat
    if (k >= RATIO) begin : g_pad
      assign beat_mux[k] = '0;
    end else if (IS_MSB) begin : g_msb
      assign beat_mux[k] = word_q[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
    end else begin : g_lsb
      assign beat_mux[k] = word_q[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // Handshake: a beat moves on every cycle where m_valid && m_ready; while
  // m_valid is high and m_ready low, m_data and m_last are held unchanged.
  assign m_valid = held_q;
  assign m_last  = held_q && (cnt_q == LAST_CNT);
  assign m_data  = beat_mux[cnt_q];
  assign busy    = held_q || pending_q;
  assign xfer    = held_q && m_ready;

  always_comb begin
    fifo_rd_en = 1'b0;
    if (!reset && !fifo_empty) begin
      if (IS_FWFT) begin
        fifo_rd_en = !held_q || (m_last && m_ready);
      end else begin
        fifo_rd_en = !held_q && !pending_q;
      end
    end
  end

  // FWFT data is present with the strobe; STANDARD data returns with fifo_valid.
  assign load = IS_FWFT ? fifo_rd_en : (fifo_valid && pending_q);

  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    pending_d = pending_q;
    if (xfer) begin
      if (m_last) begin
        cnt_d  = '0;
        held_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (load) begin
      word_d = fifo_dout;
      cnt_d  = '0;
      held_d = 1'b1;
    end
    if (!IS_FWFT) begin
      if (fifo_rd_en) begin
        pending_d = 1'b1;
      end else if (fifo_valid && pending_q) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q    <= '0;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: three instances (FWFT/LSB, FWFT/MSB, STANDARD/LSB),
// a cycle table, directed multi-cycle sequences and a randomized stream scoreboard.
module tb_fifo_rd_unpacker;
  localparam int IW    = 128;
  localparam int OW    = 16;
  localparam int RATIO = IW / OW;
  localparam logic [IW-1:0] W0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]         i_empty, i_valid, i_ready;
  logic [2:0][IW-1:0] i_dout;
  logic [2:0]         o_rd, o_valid, o_last, o_busy;
  logic [2:0][OW-1:0] o_data;

  fifo_rd_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MODE("FWFT"), .DIRECTION("LSB")) u_fwft_lsb (
    .clock(clock), .reset(reset), .fifo_empty(i_empty[0]), .fifo_dout(i_dout[0]),
    .fifo_valid(i_valid[0]), .fifo_rd_en(o_rd[0]), .m_valid(o_valid[0]), .m_ready(i_ready[0]),
    .m_data(o_data[0]), .m_last(o_last[0]), .busy(o_busy[0]));
  fifo_rd_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MODE("FWFT"), .DIRECTION("MSB")) u_fwft_msb (
    .clock(clock), .reset(reset), .fifo_empty(i_empty[1]), .fifo_dout(i_dout[1]),
    .fifo_valid(i_valid[1]), .fifo_rd_en(o_rd[1]), .m_valid(o_valid[1]), .m_ready(i_ready[1]),
    .m_data(o_data[1]), .m_last(o_last[1]), .busy(o_busy[1]));
  fifo_rd_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MODE("STANDARD"), .DIRECTION("LSB")) u_std_lsb (
    .clock(clock), .reset(reset), .fifo_empty(i_empty[2]), .fifo_dout(i_dout[2]),
    .fifo_valid(i_valid[2]), .fifo_rd_en(o_rd[2]), .m_valid(o_valid[2]), .m_ready(i_ready[2]),
    .m_data(o_data[2]), .m_last(o_last[2]), .busy(o_busy[2]));

  typedef struct packed {
    logic [1:0]    sel;
    logic          empty;
    logic          rdy;
    logic          ev;
    logic [OW-1:0] ed;
    logic          el;
    logic          erd;
    logic          eb;
  } vec_t;

  vec_t           tbl[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             sel     = 0;
  int             cyc     = 0;
  int             n_xfer  = 0;
  logic [IW-1:0]  fq[$];
  logic [OW:0]    exp_q[$];
  bit             vhist[$];
  int             rdcyc[$];
  bit             std_vld = 1'b0;
  logic [IW-1:0]  std_dat = '0;
  bit             prev_stall = 1'b0;
  logic [OW:0]    prev_beat = '0;
  bit             cap_first = 1'b0;
  logic [OW:0]    first_beat = '0;

  function automatic logic [OW-1:0] beat_of(logic [IW-1:0] w, int k, bit msb);
    int idx;
    idx = msb ? (RATIO - 1 - k) : k;
    return OW'(w >> (idx * OW));
  endfunction

  function automatic logic [IW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_empty = '1;
    i_valid = '0;
    i_ready = '0;
    i_dout  = '0;
  endtask

  task automatic clear_logs();
    vhist.delete();
    rdcyc.delete();
    n_xfer     = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    std_vld    = 1'b0;
  endtask

  // One clock of the queue-fed harness; starts and ends 1 time unit after a rising edge.
  task automatic cycle(input bit rdy, input bit spur);
    bit s_rd, s_v, s_l, s_e;
    logic [OW-1:0] s_d;
    logic [IW-1:0] w;
    drive_idle();
    i_empty[sel] = (fq.size() == 0);
    i_ready[sel] = rdy;
    if (sel == 2) begin
      i_valid[sel] = std_vld || spur;
      i_dout[sel]  = std_vld ? std_dat : rand_word();
    end else begin
      i_dout[sel] = (fq.size() != 0) ? fq[0] : rand_word();
    end
    @(negedge clock);
    s_rd = o_rd[sel];
    s_v  = o_valid[sel];
    s_l  = o_last[sel];
    s_d  = o_data[sel];
    s_e  = i_empty[sel];
    vhist.push_back(s_v);
    if (s_rd) rdcyc.push_back(cyc);
    if (s_e) chk("rd_en_while_empty", s_rd, 0);
    if (prev_stall) begin
      chk("stall_valid", s_v, 1);
      chk("stall_beat", {s_l, s_d}, prev_beat);
    end
    prev_stall = s_v && !rdy;
    prev_beat  = {s_l, s_d};
    @(posedge clock);
    #1;
    cyc++;
    std_vld = 1'b0;
    if (s_rd && fq.size() != 0) begin
      w = fq.pop_front();
      for (int k = 0; k < RATIO; k++) begin
        logic lk;
        lk = (k == RATIO - 1);
        exp_q.push_back({lk, beat_of(w, k, sel == 1)});
      end
      if (sel == 2) begin
        std_vld = 1'b1;
        std_dat = w;
      end
    end
    if (s_v && rdy) begin
      n_xfer++;
      if (cap_first) begin
        first_beat = {s_l, s_d};
        cap_first  = 1'b0;
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", {s_l, s_d}, $time);
      end else begin
        chk("beat", {s_l, s_d}, exp_q.pop_front());
      end
    end
  endtask

  task automatic add(input int s, input bit e, input bit r, input bit ev, input int ed,
                     input bit el, input bit erd, input bit eb);
    vec_t v;
    v.sel = 2'(s); v.empty = e; v.rdy = r; v.ev = ev; v.ed = OW'(ed);
    v.el = el; v.erd = erd; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    int runs[$];
    int run_len;
    int first_v;
    int vcount;
    logic [IW-1:0] wa, wb;

    // FWFT/LSB: single word, stall at beat 2, back-to-back reload on beat 7.
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 2, 0, 0, 1);
    add(0, 1, 1, 1, 2, 0, 0, 1);
    for (int k = 3; k < 7; k++) add(0, 1, 1, 1, k, 0, 0, 1);
    add(0, 0, 1, 1, 7, 1, 1, 1);
    for (int k = 0; k < 8; k++) add(0, 1, 1, 1, k, k == 7, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    // FWFT/MSB: same word emitted highest slice first.
    add(1, 0, 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) add(1, 1, 1, 1, 7 - k, k == 7, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, 0);

    // Reset state, with a non-empty FIFO to show the strobe is held off.
    drive_idle();
    i_empty = '0;
    i_ready = '1;
    i_dout  = '1;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid[%0d]", d), o_valid[d], 0);
      chk($sformatf("reset_last[%0d]", d), o_last[d], 0);
      chk($sformatf("reset_data[%0d]", d), o_data[d], 0);
      chk($sformatf("reset_rd[%0d]", d), o_rd[d], 0);
      chk($sformatf("reset_busy[%0d]", d), o_busy[d], 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_idle();

    foreach (tbl[i]) begin
      drive_idle();
      i_empty[tbl[i].sel] = tbl[i].empty;
      i_dout[tbl[i].sel]  = W0;
      i_ready[tbl[i].sel] = tbl[i].rdy;
      @(negedge clock);
      chk($sformatf("tbl%0d_valid", i), o_valid[tbl[i].sel], tbl[i].ev);
      chk($sformatf("tbl%0d_rd", i), o_rd[tbl[i].sel], tbl[i].erd);
      chk($sformatf("tbl%0d_busy", i), o_busy[tbl[i].sel], tbl[i].eb);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), o_data[tbl[i].sel], tbl[i].ed);
        chk($sformatf("tbl%0d_last", i), o_last[tbl[i].sel], tbl[i].el);
      end
      @(posedge clock);
      #1;
    end

    // FWFT two words queued: 16 gapless beats, strobes 8 cycles apart.
    sel = 0;
    clear_logs();
    wa = rand_word();
    wb = rand_word();
    fq.push_back(wa);
    fq.push_back(wb);
    for (int i = 0; i < 20; i++) cycle(1, 0);
    chk("fwft2_rd_count", rdcyc.size(), 2);
    if (rdcyc.size() == 2) chk("fwft2_rd_spacing", rdcyc[1] - rdcyc[0], 8);
    first_v = -1;
    foreach (vhist[i]) if (vhist[i] && first_v < 0) first_v = i;
    run_len = 0;
    if (first_v >= 0)
      for (int i = first_v; i < vhist.size() && vhist[i]; i++) run_len++;
    chk("fwft2_gapless_run", run_len, 16);
    chk("fwft2_xfers", n_xfer, 16);

    // STANDARD two words: two runs of 8 separated by idle cycles; then stray fifo_valid.
    sel = 2;
    clear_logs();
    fq.push_back(rand_word());
    fq.push_back(rand_word());
    for (int i = 0; i < 25; i++) cycle(1, 0);
    run_len = 0;
    foreach (vhist[i]) begin
      if (vhist[i]) run_len++;
      else if (run_len != 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
    if (run_len != 0) runs.push_back(run_len);
    chk("std_run_count", runs.size(), 2);
    if (runs.size() == 2) begin
      chk("std_run0_len", runs[0], 8);
      chk("std_run1_len", runs[1], 8);
    end
    chk("std_rd_count", rdcyc.size(), 2);
    clear_logs();
    for (int i = 0; i < 5; i++) cycle(1, 1);
    vcount = 0;
    foreach (vhist[i]) vcount += int'(vhist[i]);
    chk("std_spurious_valid", vcount, 0);
    @(negedge clock);
    chk("std_spurious_busy", o_busy[2], 0);
    @(posedge clock);
    #1;

    // Reset after beat 3 transfers; next word must restart at beat 0.
    sel = 0;
    clear_logs();
    wa = rand_word();
    wb = rand_word();
    fq.push_back(wa);
    fq.push_back(wb);
    for (int i = 0; i < 20 && n_xfer < 4; i++) cycle(1, 0);
    chk("rst_reached_beat3", n_xfer, 4);
    drive_idle();
    i_empty[0] = 1'b0;
    i_ready[0] = 1'b1;
    i_dout[0]  = wb;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", o_valid[0], 0);
    chk("rst_mid_busy", o_busy[0], 0);
    chk("rst_mid_rd", o_rd[0], 0);
    chk("rst_mid_data", o_data[0], 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cap_first = 1'b1;
    n_xfer = 0;
    for (int i = 0; i < 30 && n_xfer < 8; i++) cycle(1, 0);
    chk("rst_next_word_beats", n_xfer, 8);
    chk("rst_next_beat0", first_beat, {1'b0, beat_of(wb, 0, 0)});

    // Randomized traffic on every instance against the stream scoreboard.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      clear_logs();
      for (int i = 0; i < 400; i++) begin
        if (fq.size() < 3 && $urandom_range(0, 2) == 0) fq.push_back(rand_word());
        cycle($urandom_range(0, 3) != 0, (s == 2) && ($urandom_range(0, 7) == 0));
      end
      for (int i = 0; i < 150 && (exp_q.size() != 0 || fq.size() != 0); i++) cycle(1, 0);
      chk($sformatf("rand%0d_drained", s), exp_q.size() + fq.size(), 0);
      exp_q.delete();
      fq.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
